// File: rtl/sop_response_checker.sv
// Exhaustive response checker for a small combinational DUT: sweeps every input vector,
// samples f_in after a settle delay and scores it against a truth-table parameter.
module sop_response_checker #(
    parameter int unsigned N_IN = 3,
    parameter logic [(2**N_IN)-1:0] EXPECTED = 8'hE8,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            f_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            fail_valid
);

    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] CntReload = CntW'(SETTLE - 1);
    localparam logic [N_IN-1:0] StimMax = '1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StCheck = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] first_q, first_d;
    logic            fvalid_q, fvalid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            mismatch;

    // Only meaningful in CHECK; f_in is ignored everywhere else.
    assign mismatch = (f_in != EXPECTED[stim_q]);

    always_comb begin
        state_d  = state_q;
        stim_d   = stim_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        first_d  = first_q;
        fvalid_d = fvalid_q;
        pass_d   = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StWait;
                    stim_d   = '0;
                    cnt_d    = CntReload;
                    err_d    = '0;
                    first_d  = '0;
                    fvalid_d = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d = err_q + (N_IN+1)'(1);
                    if (!fvalid_q) begin
                        first_d  = stim_q;
                        fvalid_d = 1'b1;
                    end
                end
                if (stim_q == StimMax) begin
                    state_d = StDone;
                    pass_d  = (err_q == '0) && !mismatch;
                end else begin
                    state_d = StWait;
                    stim_d  = stim_q + 1'b1;
                    cnt_d   = CntReload;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StWait) || (state_d == StCheck);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            stim_q   <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            first_q  <= '0;
            fvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stim_q   <= stim_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            first_q  <= first_d;
            fvalid_q <= fvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = first_q;
    assign fail_valid = fvalid_q;

endmodule
